// File: rtl/pwm_frame_pkg.sv
// pwm_frame_pkg: shared types and constants for the PWM framing layer.
// Holds the framer state encoding, the symbol width and the width of the
// optional statistics counters (enabled by PWM_FRAME_STATS_EN in the top).

package pwm_frame_pkg;

    localparam int SYM_W  = 8;
    localparam int STAT_W = 16;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LENGTH  = 3'd1,
        PAYLOAD = 3'd2,
        CHECK   = 3'd3,
        DRAIN   = 3'd4
    } frame_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        return (value == {STAT_W{1'b1}}) ? value : value + STAT_W'(1);
    endfunction

endpackage

// File: rtl/pwm_frame_buffer.sv
// pwm_frame_buffer: simple dual-port payload store, DEPTH x SYM_W.
// One write port and one registered read port with one cycle of read latency.
// rd_data only changes on rd_en, so it can drive the output bus directly and
// stays stable while the consumer stalls.

module pwm_frame_buffer
    import pwm_frame_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [SYM_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [SYM_W-1:0] rd_data
);

    logic [SYM_W-1:0] mem [DEPTH];

    // Payload write port.
    // NOTE: the storage array has no reset so it can map onto RAM; a stale
    // frame is never read because reads are bounded by the latched length.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its value whenever rd_en is low.
    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pwm_frame_sync.sv
// pwm_frame_sync: hunts for a sync preamble in the decoded PWM symbol stream,
// collects a length-prefixed, XOR-checked payload into a buffer and releases
// checksum-valid frames as a valid/ready/last byte stream.
// Optional macro PWM_FRAME_STATS_EN adds saturating ok/err/drop counters.

module pwm_frame_sync
    import pwm_frame_pkg::*;
#(
    parameter logic [SYM_W-1:0] SYNC_SYMBOL    = 8'h7E,
    parameter int               SYNC_COUNT     = 3,
    parameter int               MAX_LEN        = 32,
    parameter int               TIMEOUT_CYCLES = 1024
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic signed [SYM_W-1:0] decoded_symbol,
    input  logic                    symbol_strobe,
    output logic [SYM_W-1:0]        out_data,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    frame_ok,
    output logic                    frame_err,
    output logic                    symbol_drop
`ifdef PWM_FRAME_STATS_EN
    ,
    output logic [STAT_W-1:0]       stat_ok_count,
    output logic [STAT_W-1:0]       stat_err_count,
    output logic [STAT_W-1:0]       stat_drop_count
`endif
);

    localparam int AW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int SYNC_W = (SYNC_COUNT > 1) ? $clog2(SYNC_COUNT + 1) : 1;
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    frame_state_t      state;
    logic [SYNC_W-1:0] sync_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [SYM_W-1:0]  len;
    logic [SYM_W-1:0]  checksum;
    logic [SYM_W-1:0]  wr_idx;
    logic [SYM_W-1:0]  rd_idx;

    // The symbol is a raw bit pattern; the signed port type carries no meaning here.
    logic [SYM_W-1:0] sym;
    assign sym = decoded_symbol;

    logic in_frame;
    logic timed_out;
    logic wr_en;
    logic rd_fire;

    assign in_frame  = (state == LENGTH) || (state == PAYLOAD) || (state == CHECK);
    assign timed_out = in_frame && !symbol_strobe &&
                       (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
    assign wr_en     = (state == PAYLOAD) && symbol_strobe;

    // Prefetch: fetch the next byte whenever the output register is empty or
    // is being emptied this cycle, which keeps back-to-back transfers bubble-free.
    assign rd_fire   = (state == DRAIN) && (rd_idx < len) && (!out_valid || out_ready);

    pwm_frame_buffer #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buffer (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_addr (wr_idx[AW-1:0]),
        .wr_data (sym),
        .rd_en   (rd_fire),
        .rd_addr (rd_idx[AW-1:0]),
        .rd_data (out_data)
    );

    // Idle counter: counts strobe-free cycles while a frame is being collected.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (!in_frame || symbol_strobe || timed_out) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    // Framer FSM with registered pulses and output handshake.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= HUNT;
            sync_cnt    <= '0;
            len         <= '0;
            checksum    <= '0;
            wr_idx      <= '0;
            rd_idx      <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            symbol_drop <= 1'b0;
        end else begin
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            symbol_drop <= 1'b0;

            unique case (state)
                HUNT: begin
                    if (symbol_strobe) begin
                        if (sym == SYNC_SYMBOL) begin
                            if (sync_cnt == SYNC_W'(SYNC_COUNT - 1)) begin
                                sync_cnt <= '0;
                                state    <= LENGTH;
                            end else begin
                                sync_cnt <= sync_cnt + SYNC_W'(1);
                            end
                        end else begin
                            sync_cnt <= '0;
                        end
                    end
                end

                LENGTH: begin
                    if (timed_out) begin
                        frame_err <= 1'b1;
                        state     <= HUNT;
                    end else if (symbol_strobe && (sym != SYNC_SYMBOL)) begin
                        // Extra preamble symbols are skipped; anything else is the length.
                        if ((sym == '0) || (sym > SYM_W'(MAX_LEN))) begin
                            frame_err <= 1'b1;
                            state     <= HUNT;
                        end else begin
                            len      <= sym;
                            checksum <= sym;
                            wr_idx   <= '0;
                            state    <= PAYLOAD;
                        end
                    end
                end

                PAYLOAD: begin
                    if (timed_out) begin
                        frame_err <= 1'b1;
                        state     <= HUNT;
                    end else if (symbol_strobe) begin
                        checksum <= checksum ^ sym;
                        wr_idx   <= wr_idx + SYM_W'(1);
                        if (wr_idx == len - SYM_W'(1)) begin
                            state <= CHECK;
                        end
                    end
                end

                CHECK: begin
                    if (timed_out) begin
                        frame_err <= 1'b1;
                        state     <= HUNT;
                    end else if (symbol_strobe) begin
                        if (sym == checksum) begin
                            frame_ok <= 1'b1;
                            rd_idx   <= '0;
                            state    <= DRAIN;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= HUNT;
                        end
                    end
                end

                DRAIN: begin
                    // Incoming symbols cannot be stored while the buffer is read out.
                    if (symbol_strobe) begin
                        symbol_drop <= 1'b1;
                    end
                    if (rd_fire) begin
                        rd_idx    <= rd_idx + SYM_W'(1);
                        out_valid <= 1'b1;
                        out_last  <= (rd_idx == len - SYM_W'(1));
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            state <= HUNT;
                        end
                    end
                end

                default: begin
                    state <= HUNT;
                end
            endcase
        end
    end

`ifdef PWM_FRAME_STATS_EN
    // Saturating event counters, one per status pulse.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stat_ok_count   <= '0;
            stat_err_count  <= '0;
            stat_drop_count <= '0;
        end else begin
            if (frame_ok) begin
                stat_ok_count <= sat_inc(stat_ok_count);
            end
            if (frame_err) begin
                stat_err_count <= sat_inc(stat_err_count);
            end
            if (symbol_drop) begin
                stat_drop_count <= sat_inc(stat_drop_count);
            end
        end
    end
`else
    // Statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_pwm_frame_sync.sv
// tb_pwm_frame_sync: directed frames with hand-computed checksums. Stimulus
// pushes expected bytes and frame events into queues; a negedge monitor pops
// and compares them whenever the DUT presents a byte or a status pulse.

`timescale 1ns/1ps

module tb_pwm_frame_sync;
    import pwm_frame_pkg::*;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic signed [7:0] decoded_symbol = '0;
    logic              symbol_strobe = 1'b0;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_ready = 1'b1;
    logic              frame_ok;
    logic              frame_err;
    logic              symbol_drop;
`ifdef PWM_FRAME_STATS_EN
    logic [15:0]       stat_ok_count;
    logic [15:0]       stat_err_count;
    logic [15:0]       stat_drop_count;
`endif

    always #5 clock = ~clock;

    pwm_frame_sync dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .decoded_symbol (decoded_symbol),
        .symbol_strobe  (symbol_strobe),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_last       (out_last),
        .out_ready      (out_ready),
        .frame_ok       (frame_ok),
        .frame_err      (frame_err),
        .symbol_drop    (symbol_drop)
`ifdef PWM_FRAME_STATS_EN
        ,
        .stat_ok_count   (stat_ok_count),
        .stat_err_count  (stat_err_count),
        .stat_drop_count (stat_drop_count)
`endif
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_byte_t;

    exp_byte_t  exp_q[$];
    bit         ev_q[$];      // 1 = frame_err expected, 0 = frame_ok expected
    logic [7:0] pay_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         drop_count = 0;
    bit         prev_xfer_nonlast = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: scoreboard for bytes and status pulses.
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_xfer_nonlast = 1'b0;
        end else begin
            if (prev_xfer_nonlast) begin
                check("no_bubble", out_valid, 1'b1);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now($sformatf("unexpected_byte data=%02h", out_data));
                end else begin
                    check("out_data", out_data, exp_q[0].data);
                    check("out_last", out_last, exp_q[0].last);
                    if (out_ready) begin
                        exp_q.delete(0);
                    end
                end
            end
            prev_xfer_nonlast = out_valid && out_ready && !out_last;

            if (frame_ok && frame_err) begin
                fail_now("ok_and_err_together");
            end else if (frame_ok || frame_err) begin
                if (ev_q.size() == 0) begin
                    fail_now($sformatf("unexpected_event ok=%0b err=%0b", frame_ok, frame_err));
                end else begin
                    check("frame_event_is_err", frame_err, ev_q[0]);
                    ev_q.delete(0);
                end
            end
            if (symbol_drop) begin
                drop_count++;
            end
        end
    end

    // One strobe; entered and left at posedge+1 so strobes can run back-to-back.
    task automatic send(input logic [7:0] s);
        decoded_symbol = s;
        symbol_strobe  = 1'b1;
        @(posedge clock);
        #1;
        symbol_strobe  = 1'b0;
    endtask

    // Preamble, length, pay_q and check symbol; good is the hand-decided outcome.
    task automatic frame(input int pre, input logic [7:0] len, input logic [7:0] chk, input bit good);
        for (int i = 0; i < pre; i++) send(8'h7E);
        send(len);
        foreach (pay_q[i]) send(pay_q[i]);
        if (good) begin
            ev_q.push_back(1'b0);
            foreach (pay_q[i]) exp_q.push_back({pay_q[i], (i == pay_q.size() - 1)});
        end else begin
            ev_q.push_back(1'b1);
        end
        send(chk);
    endtask

    task automatic bad_len(input logic [7:0] len);
        for (int i = 0; i < 3; i++) send(8'h7E);
        ev_q.push_back(1'b1);
        send(len);
    endtask

    // Wait until every expected byte and event has been seen, within a budget.
    task automatic wait_quiet(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ev_q.size() != 0 || out_valid) && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        check(name, (n < budget), 1'b1);
        if (n >= budget) begin
            exp_q.delete();
            ev_q.delete();
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat;
        int         drops_before;
        int         n;

        // Reset values
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_frame_ok", frame_ok, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_symbol_drop", symbol_drop, 1'b0);
        check("rst_state", dut.state, HUNT);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Good frame: 03,11,22,33 check 03
        pay_q = '{8'h11, 8'h22, 8'h33};
        frame(3, 8'h03, 8'h03, 1'b1);
        wait_quiet("good_frame_done", 50);

        // Bad checksum, then a good frame
        frame(3, 8'h03, 8'h04, 1'b0);
        wait_quiet("bad_chk_done", 50);
        check("state_after_bad_chk", dut.state, HUNT);
        frame(3, 8'h03, 8'h03, 1'b1);
        wait_quiet("good_after_bad_done", 50);

        // Broken sync then long preamble: only AA,BB delivered
        send(8'h7E);
        send(8'h7E);
        send(8'h05);
        pay_q = '{8'hAA, 8'hBB};
        frame(5, 8'h02, 8'h13, 1'b1);
        wait_quiet("long_preamble_done", 50);

        // Length bounds: 0 and 33 rejected, 32 accepted (0x40..0x5F xor to 0)
        bad_len(8'h00);
        wait_quiet("len0_done", 50);
        bad_len(8'd33);
        wait_quiet("len33_done", 50);
        pay_q.delete();
        for (int i = 0; i < 32; i++) pay_q.push_back(8'h40 + 8'(i));
        frame(3, 8'h20, 8'h20, 1'b1);
        wait_quiet("len32_done", 100);

        // Backpressure 1,0,0,1 with four strobes during DRAIN; check 05^01^02^03^04^05 = 04
        pay_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        drops_before = drop_count;
        pat = 4'b1001;
        frame(3, 8'h05, 8'h04, 1'b1);
        fork
            begin
                for (int i = 0; i < 4; i++) send(8'h7E);
            end
            begin
                for (int j = 0; j < 20; j++) begin
                    out_ready = pat[j % 4];
                    @(posedge clock);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_quiet("backpressure_done", 50);
        check("drop_pulses", drop_count - drops_before, 4);

        // Timeout mid-PAYLOAD, then recovery
        for (int i = 0; i < 3; i++) send(8'h7E);
        send(8'h04);
        send(8'h01);
        send(8'h02);
        ev_q.push_back(1'b1);
        wait_quiet("timeout_done", 1200);
        check("state_after_timeout", dut.state, HUNT);
        pay_q = '{8'h11, 8'h22, 8'h33};
        frame(3, 8'h03, 8'h03, 1'b1);
        wait_quiet("good_after_timeout_done", 50);

`ifdef PWM_FRAME_STATS_EN
        check("stat_drop_before_reset", stat_drop_count, 16'd4);
        check("stat_err_before_reset", stat_err_count, 16'd4);
`endif

        // Reset while a frame is stalled in DRAIN; C1^C2 = 03, 02^03 = 01
        out_ready = 1'b0;
        pay_q = '{8'hC1, 8'hC2};
        frame(3, 8'h02, 8'h01, 1'b1);
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("stall_valid_seen", out_valid, 1'b1);
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("mid_drain_rst_valid", out_valid, 1'b0);
        check("mid_drain_rst_last", out_last, 1'b0);
`ifdef PWM_FRAME_STATS_EN
        check("rst_stat_ok", stat_ok_count, 16'd0);
        check("rst_stat_err", stat_err_count, 16'd0);
        check("rst_stat_drop", stat_drop_count, 16'd0);
`endif
        exp_q.delete();
        reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("no_resume_after_reset", out_valid, 1'b0);

        // Single-byte frame after reset: 01^5A = 5B
        pay_q = '{8'h5A};
        frame(3, 8'h01, 8'h5B, 1'b1);
        wait_quiet("post_reset_frame_done", 50);

        check("exp_queue_empty", exp_q.size(), 0);
        check("event_queue_empty", ev_q.size(), 0);
        check("total_drops", drop_count, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
